// File: rtl/bcd_clock_pkg.sv
// Shared limits, reset constants and load-validity check for the BCD time-of-day clock.
// Pure declarations: no logic, no latency.
// No flow control of its own.
package bcd_clock_pkg;

    localparam logic [3:0] UNITS_MAX    = 4'd9;
    localparam logic [3:0] SEC_TENS_MAX = 4'd5;
    localparam logic [3:0] MIN_TENS_MAX = 4'd5;

    localparam int MODE_12H = 12;
    localparam int MODE_24H = 24;

    localparam logic [1:0] RST_HOUR_TENS_12H  = 2'd1;
    localparam logic [3:0] RST_HOUR_UNITS_12H = 4'd2;
    localparam logic [1:0] RST_HOUR_TENS_24H  = 2'd0;
    localparam logic [3:0] RST_HOUR_UNITS_24H = 4'd0;

    typedef struct packed {
        logic [3:0] sec_units;
        logic [3:0] sec_tens;
        logic [3:0] min_units;
        logic [3:0] min_tens;
        logic [3:0] hour_units;
        logic [1:0] hour_tens;
    } bcd_time_t;

    // Hour range depends on mode: 12h accepts 01..12, 24h accepts 00..23.
    function automatic logic load_valid(input int mode, input bcd_time_t t);
        logic [5:0] hour;
        logic       digits_ok;
        hour = ({4'b0, t.hour_tens} * 6'd10) + {2'b0, t.hour_units};
        digits_ok = (t.sec_units <= UNITS_MAX) && (t.sec_tens <= SEC_TENS_MAX) &&
                    (t.min_units <= UNITS_MAX) && (t.min_tens <= MIN_TENS_MAX) &&
                    (t.hour_units <= UNITS_MAX);
        if (mode == MODE_12H)
            return digits_ok && (hour >= 6'd1) && (hour <= 6'd12);
        else
            return digits_ok && (hour <= 6'd23);
    endfunction

endpackage

// File: rtl/bcd_mod60.sv
// One BCD tens/units pair counting 00..59 with load and combinational wrap.
// Latency: value updates on the edge after inc/load; wrap is same-cycle.
// No backpressure; load wins over inc.
module bcd_mod60
    import bcd_clock_pkg::*;
#(
    parameter logic [3:0] TENS_MAX = SEC_TENS_MAX
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       inc,
    input  logic       load,
    input  logic [3:0] ld_units,
    input  logic [3:0] ld_tens,
    output logic [3:0] units,
    output logic [3:0] tens,
    output logic       wrap
);

    assign wrap = inc && (units == UNITS_MAX) && (tens == TENS_MAX);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            units <= 4'd0;
            tens  <= 4'd0;
        end else if (load) begin
            units <= ld_units;
            tens  <= ld_tens;
        end else if (inc) begin
            if (units == UNITS_MAX) begin
                units <= 4'd0;
                tens  <= (tens == TENS_MAX) ? 4'd0 : tens + 4'd1;
            end else begin
                units <= units + 4'd1;
            end
        end
    end

endmodule

// File: rtl/bcd_clock_param.sv
// BCD time-of-day clock, 12h/24h by parameter, prescaled 1 s advance, load port and roll strobes.
// Latency: new time and its strobes appear together one cycle after the advancing/loading edge.
// No backpressure; en=0 freezes time and prescaler phase, load is accepted every cycle.
module bcd_clock_param
    import bcd_clock_pkg::*;
#(
    parameter int HOUR_MODE = 12,
    parameter int TICK_DIV  = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic       load,
    input  logic [3:0] ld_sec_units,
    input  logic [3:0] ld_sec_tens,
    input  logic [3:0] ld_min_units,
    input  logic [3:0] ld_min_tens,
    input  logic [3:0] ld_hour_units,
    input  logic [1:0] ld_hour_tens,
    input  logic       ld_pm,
    output logic [3:0] sec_units,
    output logic [3:0] sec_tens,
    output logic [3:0] min_units,
    output logic [3:0] min_tens,
    output logic [3:0] hour_units,
    output logic [1:0] hour_tens,
    output logic       pm,
    output logic       sec_tick,
    output logic       min_roll,
    output logic       hour_roll,
    output logic       day_roll,
    output logic       load_err
);

    localparam int            PW      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PS_LAST = PW'(TICK_DIV - 1);
    localparam bit            IS_12H  = (HOUR_MODE == MODE_12H);
    localparam logic [1:0]    RST_HT  = IS_12H ? RST_HOUR_TENS_12H  : RST_HOUR_TENS_24H;
    localparam logic [3:0]    RST_HU  = IS_12H ? RST_HOUR_UNITS_12H : RST_HOUR_UNITS_24H;

    if (HOUR_MODE != MODE_12H && HOUR_MODE != MODE_24H) begin : g_bad_mode
        $error("bcd_clock_param: HOUR_MODE must be 12 or 24");
    end
    if (TICK_DIV < 1) begin : g_bad_div
        $error("bcd_clock_param: TICK_DIV must be at least 1");
    end

    bcd_time_t     ld_time;
    logic          ld_ok;
    logic          ld_bad;
    logic [PW-1:0] ps_cnt;
    logic          adv;
    logic          sec_wrap;
    logic          min_wrap;
    logic [1:0]    hour_tens_nxt;
    logic [3:0]    hour_units_nxt;
    logic          pm_nxt;
    logic          day_wrap;

    assign ld_time = {ld_sec_units, ld_sec_tens, ld_min_units, ld_min_tens,
                      ld_hour_units, ld_hour_tens};
    assign ld_ok   = load && load_valid(HOUR_MODE, ld_time);
    assign ld_bad  = load && !ld_ok;
    // A load in the same cycle swallows the advance entirely.
    assign adv     = en && !load && (ps_cnt == PS_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ps_cnt <= '0;
        end else if (ld_ok) begin
            ps_cnt <= '0;
        end else if (en && !load) begin
            ps_cnt <= (ps_cnt == PS_LAST) ? '0 : ps_cnt + PW'(1);
        end
    end

    bcd_mod60 #(.TENS_MAX(SEC_TENS_MAX)) u_sec (
        .clk      (clk),
        .reset    (reset),
        .inc      (adv),
        .load     (ld_ok),
        .ld_units (ld_sec_units),
        .ld_tens  (ld_sec_tens),
        .units    (sec_units),
        .tens     (sec_tens),
        .wrap     (sec_wrap)
    );

    bcd_mod60 #(.TENS_MAX(MIN_TENS_MAX)) u_min (
        .clk      (clk),
        .reset    (reset),
        .inc      (sec_wrap),
        .load     (ld_ok),
        .ld_units (ld_min_units),
        .ld_tens  (ld_min_tens),
        .units    (min_units),
        .tens     (min_tens),
        .wrap     (min_wrap)
    );

    // Hour successor; day_wrap flags the transition back to the start of day.
    always_comb begin
        hour_tens_nxt  = hour_tens;
        hour_units_nxt = hour_units;
        pm_nxt         = pm;
        day_wrap       = 1'b0;
        if (IS_12H) begin
            if (hour_tens == 2'd1 && hour_units == 4'd2) begin
                hour_tens_nxt  = 2'd0;
                hour_units_nxt = 4'd1;
            end else if (hour_tens == 2'd1 && hour_units == 4'd1) begin
                hour_units_nxt = 4'd2;
                pm_nxt         = !pm;
                day_wrap       = pm;
            end else if (hour_units == UNITS_MAX) begin
                hour_tens_nxt  = hour_tens + 2'd1;
                hour_units_nxt = 4'd0;
            end else begin
                hour_units_nxt = hour_units + 4'd1;
            end
        end else begin
            if (hour_tens == 2'd2 && hour_units == 4'd3) begin
                hour_tens_nxt  = 2'd0;
                hour_units_nxt = 4'd0;
                day_wrap       = 1'b1;
            end else if (hour_units == UNITS_MAX) begin
                hour_tens_nxt  = hour_tens + 2'd1;
                hour_units_nxt = 4'd0;
            end else begin
                hour_units_nxt = hour_units + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hour_tens  <= RST_HT;
            hour_units <= RST_HU;
            pm         <= 1'b0;
        end else if (ld_ok) begin
            hour_tens  <= ld_hour_tens;
            hour_units <= ld_hour_units;
            pm         <= IS_12H ? ld_pm : 1'b0;
        end else if (min_wrap) begin
            hour_tens  <= hour_tens_nxt;
            hour_units <= hour_units_nxt;
            pm         <= pm_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sec_tick  <= 1'b0;
            min_roll  <= 1'b0;
            hour_roll <= 1'b0;
            day_roll  <= 1'b0;
            load_err  <= 1'b0;
        end else begin
            sec_tick  <= adv;
            min_roll  <= sec_wrap;
            hour_roll <= min_wrap;
            day_roll  <= min_wrap && day_wrap;
            load_err  <= ld_bad;
        end
    end

endmodule
